cache_mem_arbiter: RTL

- Shares the single physical-memory line port between the L1 instruction cache (fetch-stage misses) and the L1 data cache (MEM-stage misses and writebacks).
- Owns one in-flight pmem transaction at a time, latches its address and data at grant, and steers the response back to the owning cache.
- Sits between the two caches and the pmem model or L2; the pipeline itself never touches it.

---
 rtl/cache_mem_arbiter_if.sv | 54 +++++
 rtl/cache_mem_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if
// Purpose : bundles every signal between the two L1 caches, the shared
//           physical-memory line port, and the arbiter that sits between them.
// Modports:
//   slave  - the arbiter. It takes cache requests and memory responses, and
//            drives cache responses and memory commands.
//   master - the environment: the icache, the dcache and the memory model.
// Signals :
//   i_read, i_address, i_rdata, i_resp               icache side
//   d_read, d_write, d_address, d_wdata, d_rdata,
//   d_resp                                           dcache side
//   pmem_read, pmem_write, pmem_address, pmem_wdata,
//   pmem_rdata, pmem_resp                            memory side
interface cache_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;

  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_address, d_wdata,
    output d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_address, d_wdata,
    input  d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Purpose : shares the single physical-memory line port between the L1
//           icache and the L1 dcache. Only one pmem transaction is in flight
//           at a time. Its address, and for writebacks its data, are latched
//           at grant and held until pmem_resp. The completion pulse is then
//           steered back to the cache that owns the transaction.
// Ports   :
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - cache_mem_arbiter_if.slave (cache requests/responses, pmem port)
// Config  : define CACHE_ARB_RR_EN to enable round-robin arbitration. With it
//           defined, a tie between the two caches goes to the cache that did
//           not own the previous grant. Without it, the dcache always has
//           priority and no last-owner register exists.
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input logic               clk,
  input logic               rst,
  cache_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_RD,
    D_WR
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] address_reg, address_next;
  logic [LINE_WIDTH-1:0] wdata_reg, wdata_next;
  logic                  d_req;
  logic                  grant_d;

  assign d_req = bus.d_read | bus.d_write;

`ifdef CACHE_ARB_RR_EN
  // 0 = icache owned the last grant, 1 = dcache owned it.
  logic last_owner_reg, last_owner_next;

  // The dcache loses a tie only when it also won the previous grant.
  assign grant_d = d_req & ~(bus.i_read & last_owner_reg);
`else
  // The dcache request comes from the older instruction, so it always wins.
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      address_reg <= '0;
      wdata_reg   <= '0;
`ifdef CACHE_ARB_RR_EN
      last_owner_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      address_reg <= address_next;
      wdata_reg   <= wdata_next;
`ifdef CACHE_ARB_RR_EN
      last_owner_reg <= last_owner_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    address_next = address_reg;
    wdata_next   = wdata_reg;
`ifdef CACHE_ARB_RR_EN
    last_owner_next = last_owner_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          address_next = bus.d_address;
          // A writeback beats a read from the same cache.
          if (bus.d_write) begin
            state_next = D_WR;
            wdata_next = bus.d_wdata;
          end else begin
            state_next = D_RD;
          end
`ifdef CACHE_ARB_RR_EN
          last_owner_next = 1'b1;
`endif
        end else if (bus.i_read) begin
          state_next   = I_BUSY;
          address_next = bus.i_address;
`ifdef CACHE_ARB_RR_EN
          last_owner_next = 1'b0;
`endif
        end
      end
      default: begin
        // The request inputs are deliberately ignored here. A dropped
        // request still finishes, and address/data changes are not seen.
        if (bus.pmem_resp) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  // The commands come straight from the state register, so they act as
  // registered outputs. The command rises one cycle after the request is
  // seen in IDLE.
  assign bus.pmem_read    = (state_reg == I_BUSY) || (state_reg == D_RD);
  assign bus.pmem_write   = (state_reg == D_WR);
  assign bus.pmem_address = address_reg;
  assign bus.pmem_wdata   = wdata_reg;

  // A completion in the same cycle as reset is dropped. The transaction is
  // abandoned, so its owner must not see a response.
  assign bus.i_resp = bus.pmem_resp & ~rst & (state_reg == I_BUSY);
  assign bus.d_resp = bus.pmem_resp & ~rst &
                      ((state_reg == D_RD) || (state_reg == D_WR));

  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;

endmodule
